// File: rtl/alu_ctrl_muldiv_if.sv
// Bundle of decode inputs, operands and sequencer results exchanged between
// the main control / EX stage and the ALU control multiply/divide unit.
interface alu_ctrl_muldiv_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 6
);
  logic [2:0]       alu_op;
  logic [5:0]       funct;
  logic             valid_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OPW-1:0]   operation;
  logic             illegal;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output alu_op, funct, valid_in, a, b,
    input  operation, illegal, ready, busy, done, hi, lo
  );

  modport slave (
    input  alu_op, funct, valid_in, a, b,
    output operation, illegal, ready, busy, done, hi, lo
  );
endinterface

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decode plus iterative shift-add multiply / restoring divide
// sequencer with HI/LO registers. Optional macro: SIGNED_MULDIV_EN.
module alu_ctrl_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_ctrl_muldiv_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [OPW-1:0] OP_ADD = OPW'(27);
  localparam logic [OPW-1:0] OP_SUB = OPW'(28);
  localparam logic [OPW-1:0] OP_MUL = OPW'(33);
  localparam logic [OPW-1:0] OP_DIV = OPW'(34);
  localparam logic [5:0] FUNCT_FIRST = 6'd21;
  localparam logic [5:0] FUNCT_LAST  = 6'd28;
  localparam logic [5:0] FUNCT_TO_OP = 6'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [OPW-1:0]     w_op;
  logic               w_illegal;
  logic               w_start;
  logic               w_start_div;
  logic               w_div_zero;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_partial;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [2*WIDTH-1:0] w_div_nxt;
`ifdef SIGNED_MULDIV_EN
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_is_div;
  logic               r_dz;
`endif

  // Combinational ALUOp/funct decode
  always_comb begin
    w_op      = '0;
    w_illegal = 1'b1;
    case (bus.alu_op)
      3'b000: begin
        w_op      = OP_ADD;
        w_illegal = 1'b0;
      end
      3'b001, 3'b101: begin
        w_op      = OP_SUB;
        w_illegal = 1'b0;
      end
      3'b010: begin
        if (bus.funct >= FUNCT_FIRST && bus.funct <= FUNCT_LAST) begin
          w_op      = OPW'(bus.funct + FUNCT_TO_OP);
          w_illegal = 1'b0;
        end
      end
      default: begin
        w_op      = '0;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_start     = bus.valid_in && (r_state == S_IDLE) && ((w_op == OP_MUL) || (w_op == OP_DIV));
  assign w_start_div = (w_op == OP_DIV);
  assign w_div_zero  = (bus.b == '0);

`ifdef SIGNED_MULDIV_EN
  assign w_mag_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign w_mag_b = bus.b[WIDTH-1] ? -bus.b : bus.b;
`else
  assign w_mag_a = bus.a;
  assign w_mag_b = bus.b;
`endif

  // Shift-add step: r_b holds the remaining multiplier bits, LSB first
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
  assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring step: r_a feeds dividend bits MSB first, r_acc = {remainder, quotient}
  assign w_partial = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
  assign w_ge      = (w_partial >= {1'b0, r_b});
  assign w_diff    = w_partial[WIDTH-1:0] - r_b;
  assign w_div_nxt = {(w_ge ? w_diff : w_partial[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (!w_start_div)   w_state_nxt = S_MUL;
          else if (w_div_zero) w_state_nxt = S_FIN;
          else                 w_state_nxt = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == '0) w_state_nxt = S_FIN;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and HI/LO write-back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
`ifdef SIGNED_MULDIV_EN
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
`endif
    end else begin
      r_done <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_a   <= w_mag_a;
            r_b   <= w_mag_b;
            r_cnt <= CW'(WIDTH - 1);
            r_acc <= (w_start_div && w_div_zero) ? {bus.a, {WIDTH{1'b1}}} : '0;
`ifdef SIGNED_MULDIV_EN
            r_neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            r_neg_r  <= bus.a[WIDTH-1];
            r_is_div <= w_start_div;
            r_dz     <= w_start_div && w_div_zero;
`endif
          end
        end
        S_MUL: begin
          r_acc <= w_mul_nxt;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt - CW'(1);
        end
        S_DIV: begin
          r_acc <= w_div_nxt;
          r_a   <= r_a << 1;
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIN: begin
`ifdef SIGNED_MULDIV_EN
          if (r_dz) begin
            {r_hi, r_lo} <= r_acc;
          end else if (!r_is_div) begin
            {r_hi, r_lo} <= r_neg_q ? -r_acc : r_acc;
          end else begin
            r_lo <= r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            r_hi <= r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
          end
`else
          r_hi <= r_acc[2*WIDTH-1:WIDTH];
          r_lo <= r_acc[WIDTH-1:0];
`endif
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign bus.operation = w_op;
  assign bus.illegal   = w_illegal;
  assign bus.ready     = (r_state == S_IDLE);
  assign bus.busy      = (r_state == S_MUL) || (r_state == S_DIV);
  assign bus.done      = r_done;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Randomized self-checking bench for alu_ctrl_muldiv against an arithmetic
// reference model; honours SIGNED_MULDIV_EN the same way the design does.
module tb_alu_ctrl_muldiv;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPW   = 6;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_ctrl_muldiv_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  alu_ctrl_muldiv #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Decode reference: {illegal, operation}
  function automatic logic [6:0] ref_decode(input logic [2:0] op, input logic [5:0] f);
    int tab [8] = '{27, 28, 29, 30, 31, 32, 33, 34};
    case (op)
      3'b000:         return {1'b0, 6'd27};
      3'b001, 3'b101: return {1'b0, 6'd28};
      3'b010: if (f >= 6'd21 && f <= 6'd28) return {1'b0, 6'(tab[int'(f) - 21])};
      default: ;
    endcase
    return {1'b1, 6'd0};
  endfunction

  // Arithmetic reference: {hi, lo}
  function automatic logic [63:0] ref_result(input logic [31:0] x, input logic [31:0] y, input bit div);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (div && y == 32'd0) return {x, 32'hFFFF_FFFF};
`ifdef SIGNED_MULDIV_EN
    if (!div) return 64'(sx * sy);
    return {32'(sx % sy), 32'(sx / sy)};
`else
    if (sx == sy) begin end
    if (!div) return 64'(x) * 64'(y);
    return {x % y, x / y};
`endif
  endfunction

  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input bit div);
    bus.alu_op   = 3'b010;
    bus.funct    = div ? 6'd28 : 6'd27;
    bus.a        = x;
    bus.b        = y;
    bus.valid_in = 1'b1;
  endtask

  // Waits for the done pulse of an operation whose start edge is the next posedge
  task automatic wait_done(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input bit div, input bit keep_valid);
    logic [63:0] exp;
    int          exp_lat;
    int          lat;
    int          n_busy;
    bit          seen;
    exp     = ref_result(x, y, div);
    exp_lat = (div && y == 32'd0) ? 1 : WIDTH + 1;
    lat     = 0;
    n_busy  = 0;
    seen    = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        if (!keep_valid) bus.valid_in = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        check({tag, "_started"}, 64'(bus.ready), 64'(0));
        check({tag, "_nodone0"}, 64'(bus.done), 64'(0));
      end
      if (bus.done) begin
        seen = 1'b1;
        lat  = k;
      end else if (bus.busy) begin
        n_busy++;
      end
    end
    if (!seen) check({tag, "_timeout"}, 64'(0), 64'(1));
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busycyc"}, 64'(n_busy), 64'(exp_lat == 1 ? 0 : WIDTH));
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp[63:32]));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp[31:0]));
    check({tag, "_ready"}, 64'(bus.ready), 64'(1));
  endtask

  initial begin
    logic [6:0]  dexp;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rdiv;
    int          n_done;
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    bus.alu_op   = 3'b000;
    bus.funct    = 6'd0;
    bus.valid_in = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.ready), 64'(1));
    check("rst_busy",  64'(bus.busy),  64'(0));
    check("rst_done",  64'(bus.done),  64'(0));
    check("rst_hi",    64'(bus.hi),    64'(0));
    check("rst_lo",    64'(bus.lo),    64'(0));
    rst_n = 1'b1;

    // Full decode sweep with no valid instruction
    for (int o = 0; o < 8; o++) begin
      for (int f = 0; f < 64; f++) begin
        bus.alu_op = 3'(o);
        bus.funct  = 6'(f);
        #1;
        dexp = ref_decode(bus.alu_op, bus.funct);
        check("dec_op",      64'(bus.operation), 64'(dexp[5:0]));
        check("dec_illegal", 64'(bus.illegal),   64'(dexp[6]));
      end
    end
    check("dec_no_start", 64'(bus.ready), 64'(1));

    @(negedge clk);
    start_op(32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done("mul_max", 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("mul_max_single_done", 64'(bus.done), 64'(0));

    start_op(32'd100, 32'd7, 1'b1);
    wait_done("div_100_7", 32'd100, 32'd7, 1'b1, 1'b0);

    start_op(32'd5, 32'd0, 1'b1);
    wait_done("div_zero", 32'd5, 32'd0, 1'b1, 1'b0);

    // valid_in held through busy, dropped in the done cycle: one start only
    start_op(32'd1234, 32'd5678, 1'b0);
    wait_done("hold", 32'd1234, 32'd5678, 1'b0, 1'b1);
    bus.valid_in = 1'b0;
    @(posedge clk);
    #1;
    check("hold_one_start", 64'(bus.ready), 64'(1));
    check("hold_no_busy",   64'(bus.busy),  64'(0));
    check("hold_no_done2",  64'(bus.done),  64'(0));

    // Back-to-back: second start taken on the edge right after done
    start_op(32'd100, 32'd7, 1'b1);
    wait_done("b2b_first", 32'd100, 32'd7, 1'b1, 1'b1);
    start_op(32'd77, 32'd9, 1'b0);
    wait_done("b2b_second", 32'd77, 32'd9, 1'b0, 1'b0);

    // Reset in the middle of a divide
    start_op(32'hDEAD_BEEF, 32'd3, 1'b1);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_ready", 64'(bus.ready), 64'(1));
    check("rstmid_busy",  64'(bus.busy),  64'(0));
    check("rstmid_done",  64'(bus.done),  64'(0));
    check("rstmid_hi",    64'(bus.hi),    64'(0));
    check("rstmid_lo",    64'(bus.lo),    64'(0));
    rst_n  = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) n_done++;
    end
    check("rstmid_no_done", 64'(n_done), 64'(0));
    start_op(32'd3, 32'd4, 1'b0);
    wait_done("post_rst_mul", 32'd3, 32'd4, 1'b0, 1'b0);

`ifdef SIGNED_MULDIV_EN
    start_op(-32'sd7, 32'sd2, 1'b0);
    wait_done("smul_m7_2", -32'sd7, 32'sd2, 1'b0, 1'b0);
    start_op(-32'sd7, 32'sd2, 1'b1);
    wait_done("sdiv_m7_2", -32'sd7, 32'sd2, 1'b1, 1'b0);
`endif

    // Randomized mix of mul / div, including zero and small divisors
    for (int i = 0; i < 24; i++) begin
      rdiv = 1'($urandom_range(0, 1));
      ra   = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 255));
      start_op(ra, rb, rdiv);
      wait_done("rand", ra, rb, rdiv, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
